l2_cache_control: RTL and testbench
===================================

Name: l2_cache_control

Overview:
Control FSM for the 8-way, 8-set, 256-bit-line L2 cache datapath. It takes line-granular read/write requests from the upstream L1 side and drives all datapath select and load strobes. It sequences hit service, dirty-victim writeback and line fill through the cacheline adaptor, and returns a single-cycle mem_resp to the requester.

Parameters:
NUM_WAYS, 8, ways per set; fixes the 3-bit way selects
WAY_IDX_W, 3, width of way_sel, dirty_sel, plru_idx and hit_idx

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low (asserted at 0)
mem_read  in  1  upstream line read request; level, held until mem_resp
mem_write  in  1  upstream line write request; level, held until mem_resp
mem_resp  out  1  one-cycle completion pulse to upstream
pmem_read  out  1  fill request to the cacheline adaptor
pmem_write  out  1  writeback request to the cacheline adaptor
pmem_resp  in  1  adaptor completion pulse
cache_hit  in  1  datapath: tag match on a valid way
dirty_o  in  1  datapath: dirty bit of the way selected by dirty_sel
plru_idx  in  3  datapath: PLRU victim for the current set
hit_idx  in  3  datapath: lowest hitting way
source_sel  out  1  0 = CPU data, 1 = memory data
way_sel  out  3  way for data/tag muxes and load demux
tag_sel  out  1  0 = victim tag (writeback address), 1 = request tag (fill address)
load_cache  out  1  write the selected way's data, tag and valid
load_lru  out  1  update PLRU for the current set
read_cache_data  out  1  held at 1
load_dirty_arr  out  1  write the selected way's dirty bit (value = mem_write)
dirty_sel  out  3  way whose dirty bit is presented on dirty_o
hit_count, miss_count, wb_count  out  32 each  performance counters (see Optional Feature)

Behaviour:
- States: IDLE, CHECK, WRITEBACK, FILL. Reset enters IDLE. A 3-bit victim register resets to 0.
- Reset value of all outputs is 0, except read_cache_data = 1, tag_sel = 0 and source_sel = 0.
- Outputs are combinational from state and inputs (Moore/Mealy mix). No strobe is asserted outside the state listed below.
- IDLE: if mem_read or mem_write, go to CHECK next cycle. The one cycle allows the array read settle. Otherwise stay in IDLE.
- Both mem_read and mem_write high: treated as a write.
- CHECK, cache_hit = 1:
  - way_sel = hit_idx, load_lru = 1, mem_resp = 1, then go to IDLE.
  - For a write, also assert load_cache = 1, load_dirty_arr = 1 and source_sel = 0.
  - Hit latency is 2 cycles from request to mem_resp.
- CHECK, cache_hit = 0:
  - dirty_sel = plru_idx; latch victim <= plru_idx.
  - If dirty_o, go to WRITEBACK; else go to FILL.
  - No mem_resp.
- WRITEBACK: way_sel = victim, tag_sel = 0, pmem_write = 1 held until pmem_resp. Then go to FILL.
- FILL:
  - way_sel = victim, tag_sel = 1, source_sel = 1, pmem_read = 1 held until pmem_resp.
  - On the pmem_resp cycle: load_cache = 1 and load_dirty_arr = 1, which clears or sets dirty per mem_write. Then go to CHECK.
  - The re-check hits and responds; a write merges the CPU data there.
- pmem_read and pmem_write are never high together.
- pmem_resp outside WRITEBACK/FILL is ignored.
- If the upstream request drops mid-miss, the current WRITEBACK/FILL still completes. CHECK then sees no request and returns to IDLE without mem_resp.
- Reset asserted mid-operation: state returns to IDLE immediately and the pmem strobes drop asynchronously. The adaptor is reset by the same rst.

Optional Feature:
- Macro: L2_CACHE_PERF_CNT_EN.
- When defined:
  - hit_count increments on a CHECK hit that was not reached directly from FILL.
  - miss_count increments on a CHECK miss.
  - wb_count increments on WRITEBACK exit.
  - All counters are 32-bit, saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: the ports remain and are tied to 0, with no counter flops.

Decomposition:
- Package l2_cache_types holds:
  - enum l2_state_t {IDLE, CHECK, WRITEBACK, FILL};
  - constants L2_NUM_WAYS = 8 and L2_WAY_IDX_W = 3.
- One sub-module, l2_perf_counters: three saturating counters with increment enables, instantiated only under the macro.

Test Plan:
- Read miss, clean victim: plru_idx = 5, dirty_o = 0. Expect FILL with way_sel = 5, tag_sel = 1, pmem_read until pmem_resp, load_cache on the resp cycle, then CHECK hit and mem_resp.
- Write miss, dirty victim: plru_idx = 2, dirty_o = 1. Expect pmem_write with tag_sel = 0, way_sel = 2, then pmem_read, then CHECK with load_cache = 1, source_sel = 0, load_dirty_arr = 1 and mem_resp; wb_count = 1.
- Read hit: hit_idx = 6. Expect mem_resp exactly 2 cycles after mem_read rises, load_lru = 1, load_cache = 0; hit_count = 1.
- Simultaneous read and write on a hit: the write path is taken (load_cache = 1).
- mem_read dropped during FILL: the fill completes, no mem_resp, FSM back in IDLE within 2 cycles of pmem_resp.
- rst driven low mid-WRITEBACK, between clock edges: pmem_write is 0 before the next edge; the FSM is in IDLE and counters are 0 after release.

Source files
------------

// File: rtl/l2_cache_types.sv
`default_nettype none
// ============================================================================
// Module   : l2_cache_types (package)
// Brief    : Shared state encoding and geometry constants for the L2 control.
// Revision : 1.0 - initial release
// ============================================================================
package l2_cache_types;

    localparam int L2_NUM_WAYS  = 8;
    localparam int L2_WAY_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } l2_state_t;

endpackage
`default_nettype wire

// File: rtl/l2_perf_counters.sv
`default_nettype none
// ============================================================================
// Module   : l2_perf_counters
// Brief    : Three saturating event counters (hit, miss, writeback).
// Revision : 1.0 - initial release
// ============================================================================
module l2_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit_inc,
    input  logic             miss_inc,
    input  logic             wb_inc,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    logic [2:0]       w_inc;
    logic [CNT_W-1:0] r_cnt [3];

    assign w_inc = {wb_inc, miss_inc, hit_inc};

    // Counters hold at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '{default: '0};
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_inc[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign hit_count  = r_cnt[0];
    assign miss_count = r_cnt[1];
    assign wb_count   = r_cnt[2];

endmodule
`default_nettype wire

// File: rtl/l2_cache_control.sv
`default_nettype none
// ============================================================================
// Module   : l2_cache_control
// Brief    : Control FSM for the 8-way L2 datapath: hit service, dirty-victim
//            writeback and line fill. Optional counters: L2_CACHE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module l2_cache_control
    import l2_cache_types::*;
#(
    parameter int NUM_WAYS  = L2_NUM_WAYS,
    parameter int WAY_IDX_W = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 cache_hit,
    input  logic                 dirty_o,
    input  logic [WAY_IDX_W-1:0] plru_idx,
    input  logic [WAY_IDX_W-1:0] hit_idx,
    output logic                 source_sel,
    output logic [WAY_IDX_W-1:0] way_sel,
    output logic                 tag_sel,
    output logic                 load_cache,
    output logic                 load_lru,
    output logic                 read_cache_data,
    output logic                 load_dirty_arr,
    output logic [WAY_IDX_W-1:0] dirty_sel,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count,
    output logic [31:0]          wb_count
);

    l2_state_t            r_state;
    l2_state_t            w_next_state;
    logic [WAY_IDX_W-1:0] r_victim;
    logic [WAY_IDX_W-1:0] w_victim_next;
    logic                 w_req;

    assign w_req = mem_read | mem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_victim <= '0;
        end else begin
            r_state  <= w_next_state;
            r_victim <= w_victim_next;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_victim_next   = r_victim;
        mem_resp        = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        source_sel      = 1'b0;
        way_sel         = '0;
        tag_sel         = 1'b0;
        load_cache      = 1'b0;
        load_lru        = 1'b0;
        read_cache_data = 1'b1;
        load_dirty_arr  = 1'b0;
        dirty_sel       = '0;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next_state = CHECK;
                end
            end
            CHECK: begin
                if (!w_req) begin
                    // Request withdrawn during a miss: finish quietly.
                    w_next_state = IDLE;
                end else if (cache_hit) begin
                    way_sel      = hit_idx;
                    load_lru     = 1'b1;
                    mem_resp     = 1'b1;
                    w_next_state = IDLE;
                    if (mem_write) begin
                        load_cache     = 1'b1;
                        load_dirty_arr = 1'b1;
                    end
                end else begin
                    dirty_sel     = plru_idx;
                    w_victim_next = plru_idx;
                    w_next_state  = dirty_o ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                way_sel    = r_victim;
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                way_sel    = r_victim;
                tag_sel    = 1'b1;
                source_sel = 1'b1;
                pmem_read  = 1'b1;
                if (pmem_resp) begin
                    load_cache     = 1'b1;
                    load_dirty_arr = 1'b1;
                    w_next_state   = CHECK;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

`ifdef L2_CACHE_PERF_CNT_EN
    logic r_from_fill;
    logic w_hit_inc;
    logic w_miss_inc;
    logic w_wb_inc;

    // The re-check after a fill is the tail of a miss, not a fresh hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_from_fill <= 1'b0;
        end else begin
            r_from_fill <= (r_state == FILL);
        end
    end

    assign w_hit_inc  = (r_state == CHECK) && w_req && cache_hit && !r_from_fill;
    assign w_miss_inc = (r_state == CHECK) && w_req && !cache_hit;
    assign w_wb_inc   = (r_state == WRITEBACK) && pmem_resp;

    l2_perf_counters #(
        .CNT_W (32)
    ) u_perf (
        .clk        (clk),
        .rst        (rst),
        .hit_inc    (w_hit_inc),
        .miss_inc   (w_miss_inc),
        .wb_inc     (w_wb_inc),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_cache_control
// Brief    : Scoreboard bench with a one-set datapath model and a pmem adaptor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_cache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, pmem_resp;
    logic        cache_hit, dirty_o;
    logic [2:0]  plru_idx, hit_idx;
    logic        mem_resp, pmem_read, pmem_write, source_sel, tag_sel;
    logic        load_cache, load_lru, read_cache_data, load_dirty_arr;
    logic [2:0]  way_sel, dirty_sel;
    logic [31:0] hit_count, miss_count, wb_count;

    always #5 clk = ~clk;

    l2_cache_control dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .cache_hit(cache_hit), .dirty_o(dirty_o),
        .plru_idx(plru_idx), .hit_idx(hit_idx), .source_sel(source_sel),
        .way_sel(way_sel), .tag_sel(tag_sel), .load_cache(load_cache),
        .load_lru(load_lru), .read_cache_data(read_cache_data),
        .load_dirty_arr(load_dirty_arr), .dirty_sel(dirty_sel),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int resp_cnt = 0;
    int fixed_delay = -1;
    int e_hits = 0, e_miss = 0, e_wb = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One-set datapath: 8 ways of tag/valid/dirty, driven by the DUT's strobes
    bit [7:0] m_tag   [8];
    bit       m_valid [8];
    bit       m_dirty [8];
    logic [7:0] cur_tag;

    always_comb begin
        cache_hit = 1'b0;
        hit_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m_valid[i] && (m_tag[i] == cur_tag)) begin
                cache_hit = 1'b1;
                hit_idx   = 3'(i);
            end
        end
        dirty_o = m_dirty[dirty_sel];
    end

    always @(posedge clk) begin
        if (load_cache) begin
            m_tag[way_sel]   <= cur_tag;
            m_valid[way_sel] <= 1'b1;
        end
        if (load_dirty_arr) m_dirty[way_sel] <= mem_write;
    end

    typedef struct { bit wr; bit [2:0] way; int lat; int issue; } resp_t;
    typedef struct { bit wr; bit [2:0] way; } pm_t;
    resp_t rq[$];
    pm_t   pq[$];

    // Monitor: pops expectations when the DUT presents a response or a pmem request
    initial begin : monitor
        resp_t e;
        pm_t   p;
        logic  prev_pr, prev_pw;
        prev_pr = 1'b0;
        prev_pw = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_resp) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_mem_resp", 32'd1, 32'd0);
                    end else begin
                        e = rq.pop_front();
                        chk("resp_way_sel", 32'(way_sel), 32'(e.way));
                        chk("resp_load_cache", 32'(load_cache), 32'(e.wr));
                        chk("resp_load_dirty", 32'(load_dirty_arr), 32'(e.wr));
                        chk("resp_load_lru", 32'(load_lru), 32'd1);
                        chk("resp_source_sel", 32'(source_sel), 32'd0);
                        if (e.lat != 0) chk("hit_latency", 32'(cyc - e.issue + 1), 32'(e.lat));
                    end
                    resp_cnt++;
                end
                if ((pmem_read && !prev_pr) || (pmem_write && !prev_pw)) begin
                    chk("pmem_exclusive", 32'(pmem_read && pmem_write), 32'd0);
                    if (pq.size() == 0) begin
                        chk("unexpected_pmem_req", 32'd1, 32'd0);
                    end else begin
                        p = pq.pop_front();
                        chk("pmem_is_write", 32'(pmem_write), 32'(p.wr));
                        chk("pmem_way_sel", 32'(way_sel), 32'(p.way));
                        chk("pmem_tag_sel", 32'(tag_sel), p.wr ? 32'd0 : 32'd1);
                        if (!p.wr) chk("fill_source_sel", 32'(source_sel), 32'd1);
                    end
                end
                if (pmem_read && pmem_resp) begin
                    chk("fill_load_cache", 32'(load_cache), 32'd1);
                    chk("fill_load_dirty", 32'(load_dirty_arr), 32'd1);
                end
            end
            prev_pr = pmem_read;
            prev_pw = pmem_write;
        end
    end

    // Cacheline adaptor: one-cycle pmem_resp after a short delay
    initial begin : adaptor
        pmem_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && (pmem_read || pmem_write)) begin
                int d;
                bit ab;
                d  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                ab = 1'b0;
                for (int i = 0; i < d; i++) begin
                    @(posedge clk);
                    if (!rst) begin
                        ab = 1'b1;
                        break;
                    end
                end
                if (!ab) begin
                    @(posedge clk);
                    #1;
                    if (rst) begin
                        pmem_resp = 1'b1;
                        @(posedge clk);
                        #1;
                        pmem_resp = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk_counters(input string tag);
`ifdef L2_CACHE_PERF_CNT_EN
        chk({tag, "_hit_count"},  hit_count,  32'(e_hits));
        chk({tag, "_miss_count"}, miss_count, 32'(e_miss));
        chk({tag, "_wb_count"},   wb_count,   32'(e_wb));
`else
        chk({tag, "_hit_count"},  hit_count,  32'd0);
        chk({tag, "_miss_count"}, miss_count, 32'd0);
        chk({tag, "_wb_count"},   wb_count,   32'd0);
`endif
    endtask

    // op: 0 read, 1 write, 2 read+write (behaves as write)
    task automatic do_req(input int op, input logic [7:0] tag, input logic [2:0] plru, input bit drop);
        bit    hit, wb;
        bit [2:0] hway;
        resp_t e;
        int    start;
        hit  = 1'b0;
        hway = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m_valid[i] && m_tag[i] == tag) begin
                hit  = 1'b1;
                hway = 3'(i);
            end
        end
        wb = !hit && m_valid[plru] && m_dirty[plru];
        if (hit) begin
            e_hits++;
        end else begin
            e_miss++;
            if (wb) begin
                e_wb++;
                pq.push_back('{1'b1, plru});
            end
            pq.push_back('{1'b0, plru});
        end
        cur_tag   = tag;
        plru_idx  = plru;
        mem_read  = (op != 1);
        mem_write = (op != 0);
        e.wr    = (op != 0);
        e.way   = hit ? hway : plru;
        e.lat   = hit ? 2 : 0;
        e.issue = cyc;
        if (!drop) begin
            rq.push_back(e);
            start = resp_cnt;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk);
                if (resp_cnt != start) break;
            end
            chk("resp_timeout", 32'(resp_cnt != start), 32'd1);
            #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end else begin
            start = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (pmem_read) begin
                    start = 1;
                    break;
                end
            end
            chk("drop_fill_seen", 32'(start), 32'd1);
            @(posedge clk);
            #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            chk("drop_fill_done_pmem_read", 32'(pmem_read), 32'd0);
            chk("drop_no_load_cache", 32'(load_cache), 32'd0);
        end
    endtask

    initial begin : stimulus
        int seen;
        rst = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        cur_tag = 8'd0;
        plru_idx = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_read_cache_data", 32'(read_cache_data), 32'd1);
        chk("rst_outputs_zero", 32'({mem_resp, pmem_read, pmem_write, source_sel, tag_sel,
                                     load_cache, load_lru, load_dirty_arr, way_sel, dirty_sel}), 32'd0);
        chk_counters("rst");
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_req(0, 8'd100, 3'd5, 1'b0);   // read miss, clean victim way 5
        do_req(1, 8'd101, 3'd2, 1'b0);   // write miss fills way 2 dirty
        do_req(1, 8'd102, 3'd2, 1'b0);   // write miss, dirty victim way 2
        chk_counters("after_wb");
        do_req(0, 8'd103, 3'd6, 1'b0);   // place tag in way 6
        do_req(0, 8'd103, 3'd0, 1'b0);   // read hit way 6
        do_req(2, 8'd103, 3'd0, 1'b0);   // read+write hit: write path
        do_req(0, 8'd104, 3'd3, 1'b1);   // request dropped during fill
        do_req(0, 8'd104, 3'd1, 1'b0);   // line filled anyway: hit
        chk_counters("directed");

        // Reset mid-WRITEBACK (way 2 still holds dirty tag 102)
        fixed_delay = 30;
        cur_tag   = 8'd110;
        plru_idx  = 3'd2;
        mem_write = 1'b1;
        pq.push_back('{1'b1, 3'd2});
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pmem_write) begin
                seen = 1;
                break;
            end
        end
        chk("rst_test_wb_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_async_pmem_write", 32'(pmem_write), 32'd0);
        chk("rst_async_pmem_read", 32'(pmem_read), 32'd0);
        rq.delete();
        pq.delete();
        e_hits = 0;
        e_miss = 0;
        e_wb   = 0;
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fixed_delay = -1;
        @(negedge clk);
        chk("post_rst_idle", 32'({mem_resp, pmem_read, pmem_write, load_cache}), 32'd0);
        chk_counters("post_rst");
        repeat (3) @(posedge clk);
        #1;

        for (int n = 0; n < 70; n++) begin
            do_req(int'($urandom_range(0, 2)), 8'($urandom_range(0, 11)),
                   3'($urandom_range(0, 7)), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        chk("queues_drained", 32'(rq.size() + pq.size()), 32'd0);
        chk_counters("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
